// File: rtl/sram_bank_ctrl.sv
// Dual-port (data + instruction OBI) controller for a row of 1RW1R SRAM banks.
// Zero-fills the banks after reset, then serves single-cycle-latency requests.

module sram_bank_ctrl_mem #(
    parameter int WORDS = 512
) (
    input  logic                     clk0,
    input  logic                     csb0,
    input  logic                     web0,
    input  logic [3:0]               wmask0,
    input  logic [$clog2(WORDS)-1:0] addr0,
    input  logic [31:0]              din0,
    output logic [31:0]              dout0,
    input  logic                     clk1,
    input  logic                     csb1,
    input  logic [$clog2(WORDS)-1:0] addr1,
    output logic [31:0]              dout1
);
    // Behavioural stand-in with the port list of sky130_sram_2kbyte_1rw1r_32x512_8.
    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) r_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (!csb0 && web0) dout0 <= r_mem[addr0];
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= r_mem[addr1];
    end
endmodule

module sram_bank_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          NUM_BANKS  = 3,
    parameter int          BANK_WORDS = 512,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        d_req_i,
    output logic        d_gnt_o,
    input  logic [31:0] d_addr_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_rvalid_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    input  logic        i_req_i,
    output logic        i_gnt_o,
    input  logic [31:0] i_addr_i,
    input  logic        i_we_i,
    output logic        i_rvalid_o,
    output logic        i_err_o,
    output logic [31:0] i_rdata_o,
    output logic        init_done_o,
    output logic        err_valid_o,
    output logic        err_src_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clear_i
);
    localparam int          WORD_BITS = $clog2(BANK_WORDS);
    localparam int          BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(NUM_BANKS * BANK_WORDS * 4);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 r_state, w_stateNext;
    logic [WORD_BITS-1:0]   r_initCnt, w_initCntNext;
    logic                   w_initWr, w_dGnt, w_iGnt;
    logic [31:0]            w_dOffset, w_iOffset;
    logic                   w_dLegal, w_iLegal, w_collide;
    logic [BANK_BITS-1:0]   w_dBank, w_iBank, r_dBank, r_iBank;
    logic [WORD_BITS-1:0]   w_dWord, w_iWord;
    logic                   r_dValid, r_dErr, r_dRead, r_iValid, r_iErr, r_iRead;
    logic                   r_errValid, r_errSrc;
    logic [31:0]            r_errAddr;
    logic                   w_p0Web;
    logic [3:0]             w_p0Mask;
    logic [WORD_BITS-1:0]   w_p0Addr;
    logic [31:0]            w_p0Din;
    logic [31:0]            w_dout0 [NUM_BANKS];
    logic [31:0]            w_dout1 [NUM_BANKS];

    assign w_dOffset = d_addr_i - BASE_ADDR;
    assign w_iOffset = i_addr_i - BASE_ADDR;
    assign w_dLegal  = (d_addr_i >= BASE_ADDR) && (w_dOffset < MEM_BYTES);
    assign w_iLegal  = (i_addr_i >= BASE_ADDR) && (w_iOffset < MEM_BYTES) && !i_we_i;
    assign w_dBank   = w_dOffset[WORD_BITS+2 +: BANK_BITS];
    assign w_iBank   = w_iOffset[WORD_BITS+2 +: BANK_BITS];
    assign w_dWord   = w_dOffset[WORD_BITS+1:2];
    assign w_iWord   = w_iOffset[WORD_BITS+1:2];

    // A data write to the very word the instruction side wants to read stalls the fetch.
    assign w_collide = d_req_i && d_we_i && w_dLegal && w_iLegal &&
                       (w_dBank == w_iBank) && (w_dWord == w_iWord);

    always_comb begin
        w_stateNext   = r_state;
        w_initCntNext = r_initCnt;
        w_initWr      = 1'b0;
        w_dGnt        = 1'b0;
        w_iGnt        = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_initWr      = rst_ni;
                w_initCntNext = r_initCnt + 1'b1;
                if (r_initCnt == WORD_BITS'(BANK_WORDS - 1)) begin
                    w_stateNext   = ST_RUN;
                    w_initCntNext = '0;
                end
            end
            ST_RUN: begin
                w_dGnt = rst_ni && d_req_i;
                w_iGnt = rst_ni && i_req_i && !w_collide;
            end
            default: w_stateNext = ST_INIT;
        endcase
    end

    assign w_p0Web  = w_initWr ? 1'b0 : !d_we_i;
    assign w_p0Mask = w_initWr ? 4'hF : d_be_i;
    assign w_p0Addr = w_initWr ? r_initCnt : w_dWord;
    assign w_p0Din  = w_initWr ? 32'h0 : d_wdata_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_csb0, w_csb1;
        assign w_csb0 = !(w_initWr || (w_dGnt && w_dLegal && (w_dBank == BANK_BITS'(b))));
        assign w_csb1 = !(w_iGnt && w_iLegal && (w_iBank == BANK_BITS'(b)));
        sram_bank_ctrl_mem #(.WORDS(BANK_WORDS)) u_mem (
            .clk0   (clk_i),
            .csb0   (w_csb0),
            .web0   (w_p0Web),
            .wmask0 (w_p0Mask),
            .addr0  (w_p0Addr),
            .din0   (w_p0Din),
            .dout0  (w_dout0[b]),
            .clk1   (clk_i),
            .csb1   (w_csb1),
            .addr1  (w_iWord),
            .dout1  (w_dout1[b])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= INIT_EN ? ST_INIT : ST_RUN;
            r_initCnt  <= '0;
            r_dValid   <= 1'b0;
            r_dErr     <= 1'b0;
            r_dRead    <= 1'b0;
            r_dBank    <= '0;
            r_iValid   <= 1'b0;
            r_iErr     <= 1'b0;
            r_iRead    <= 1'b0;
            r_iBank    <= '0;
            r_errValid <= 1'b0;
            r_errSrc   <= 1'b0;
            r_errAddr  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_initCnt <= w_initCntNext;
            r_dValid  <= w_dGnt;
            r_dErr    <= w_dGnt && !w_dLegal;
            r_dRead   <= w_dGnt && w_dLegal && !d_we_i;
            r_dBank   <= w_dBank;
            r_iValid  <= w_iGnt;
            r_iErr    <= w_iGnt && !w_iLegal;
            r_iRead   <= w_iGnt && w_iLegal;
            r_iBank   <= w_iBank;
            // A new error may overwrite the record only when it is empty or being cleared.
            if (!r_errValid || err_clear_i) begin
                if (w_dGnt && !w_dLegal) begin
                    r_errValid <= 1'b1;
                    r_errSrc   <= 1'b0;
                    r_errAddr  <= d_addr_i;
                end else if (w_iGnt && !w_iLegal) begin
                    r_errValid <= 1'b1;
                    r_errSrc   <= 1'b1;
                    r_errAddr  <= i_addr_i;
                end else if (err_clear_i) begin
                    r_errValid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        d_rdata_o = '0;
        i_rdata_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_dRead && (r_dBank == BANK_BITS'(b))) d_rdata_o = w_dout0[b];
            if (r_iRead && (r_iBank == BANK_BITS'(b))) i_rdata_o = w_dout1[b];
        end
    end

    assign d_gnt_o     = w_dGnt;
    assign i_gnt_o     = w_iGnt;
    assign d_rvalid_o  = r_dValid;
    assign d_err_o     = r_dErr;
    assign i_rvalid_o  = r_iValid;
    assign i_err_o     = r_iErr;
    assign init_done_o = (r_state == ST_RUN);
    assign err_valid_o = r_errValid;
    assign err_src_o   = r_errSrc;
    assign err_addr_o  = r_errAddr;
endmodule
